// File: rtl/display_page_seq_pkg.sv
// Shared page encodings and widths for the hex-display page sequencer.
package display_page_seq_pkg;

    localparam int PAGE_W       = 2;
    localparam int GOLDEN_CNT_W = 16;

    typedef logic [PAGE_W-1:0] page_t;

    localparam page_t PAGE_NONCE  = 2'd0;
    localparam page_t PAGE_GOLDEN = 2'd1;
    localparam page_t PAGE_COUNT  = 2'd2;
    localparam page_t PAGE_RATE   = 2'd3;

endpackage

// File: rtl/display_page_seq_if.sv
// Miner-status inputs and display outputs of display_page_seq; master = status source, slave = sequencer.
interface display_page_seq_if
    import display_page_seq_pkg::*;
#(
    parameter int HEX_DIGITS = 8
);

    logic [31:0]              nonce_in;
    logic [31:0]              golden_nonce_in;
    logic                     golden_valid;
    logic                     page_next;
    logic                     auto_en;
    logic [4*HEX_DIGITS-1:0]  disp_word;
    page_t                    page_idx;
    logic [GOLDEN_CNT_W-1:0]  golden_count;

    modport master (
        output nonce_in, golden_nonce_in, golden_valid, page_next, auto_en,
        input  disp_word, page_idx, golden_count
    );

    modport slave (
        input  nonce_in, golden_nonce_in, golden_valid, page_next, auto_en,
        output disp_word, page_idx, golden_count
    );

endinterface

// File: rtl/display_page_seq_dwell_timer.sv
// Modulo-N counter with enable and sync clear; tc strobes in the terminal (N-1) cycle while enabled.
module display_page_seq_dwell_timer #(
    parameter int N = 10,
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    // Disabling parks the count at zero so re-enabling always starts a full period.
    always_ff @(posedge clk) begin
        if (reset || clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_page_seq.sv
// Page sequencer feeding the 8-digit hex display with miner status words.
// Optional feature macro: DISPLAY_PAGE_SEQ_HOLD_ON_GOLDEN_EN (a golden nonce forces and holds the golden page).
module display_page_seq
    import display_page_seq_pkg::*;
#(
    parameter int HEX_DIGITS   = 8,
    parameter int DWELL_CYCLES = 100000000,
    parameter int RATE_CYCLES  = 50000000,
    parameter int HOLD_CYCLES  = 250000000
) (
    input  logic               clk,
    input  logic               reset,
    display_page_seq_if.slave  bus
);

    localparam int DISP_W = 4 * HEX_DIGITS;

    if (DWELL_CYCLES < 2 || RATE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_param
        $error("display_page_seq: DWELL_CYCLES, RATE_CYCLES and HOLD_CYCLES must be >= 2");
    end

    function automatic logic [GOLDEN_CNT_W-1:0] sat_inc(input logic [GOLDEN_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [31:0]             golden_reg;
    logic [31:0]             rate_reg;
    logic [31:0]             nonce_snap;
    logic [GOLDEN_CNT_W-1:0] golden_count;
    page_t                   page_idx;
    logic [DISP_W-1:0]       disp_word_p1;
    logic                    dwell_tc;
    logic                    rate_tc;
    logic                    dwell_clr;

`ifdef DISPLAY_PAGE_SEQ_HOLD_ON_GOLDEN_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;

    assign dwell_clr = bus.page_next || bus.golden_valid;
`else
    assign dwell_clr = bus.page_next;
`endif

    display_page_seq_dwell_timer #(.N(DWELL_CYCLES)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .en    (bus.auto_en),
        .clr   (dwell_clr),
        .tc    (dwell_tc)
    );

    display_page_seq_dwell_timer #(.N(RATE_CYCLES)) u_rate (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .tc    (rate_tc)
    );

    // Status capture: golden nonce/count and per-window nonce delta (mod 2^32 handles wrap).
    always_ff @(posedge clk) begin
        if (reset) begin
            golden_reg   <= '0;
            golden_count <= '0;
            rate_reg     <= '0;
            nonce_snap   <= '0;
        end else begin
            if (bus.golden_valid) begin
                golden_reg   <= bus.golden_nonce_in;
                golden_count <= sat_inc(golden_count);
            end
            if (rate_tc) begin
                rate_reg   <= bus.nonce_in - nonce_snap;
                nonce_snap <= bus.nonce_in;
            end
        end
    end

    // Page selection: a coincident pulse and auto tick advance by a single page.
`ifdef DISPLAY_PAGE_SEQ_HOLD_ON_GOLDEN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            page_idx <= PAGE_NONCE;
            hold_cnt <= '0;
        end else if (bus.golden_valid) begin
            page_idx <= PAGE_GOLDEN;
            hold_cnt <= HOLD_LOAD;
        end else if (bus.page_next) begin
            page_idx <= page_idx + 1'b1;
            hold_cnt <= '0;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end else if (dwell_tc) begin
            page_idx <= page_idx + 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            page_idx <= PAGE_NONCE;
        end else if (bus.page_next || dwell_tc) begin
            page_idx <= page_idx + 1'b1;
        end
    end
`endif

    // Display register stage: one cycle behind page_idx and its source values.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_word_p1 <= '0;
        end else begin
            case (page_idx)
                PAGE_NONCE:  disp_word_p1 <= DISP_W'(bus.nonce_in);
                PAGE_GOLDEN: disp_word_p1 <= DISP_W'(golden_reg);
                PAGE_COUNT:  disp_word_p1 <= DISP_W'(golden_count);
                default:     disp_word_p1 <= DISP_W'(rate_reg);
            endcase
        end
    end

    assign bus.disp_word    = disp_word_p1;
    assign bus.page_idx     = page_idx;
    assign bus.golden_count = golden_count;

endmodule
